keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
Sequencing controller for the 4x4 keypad digit-entry path feeding the 7-segment display. Debounces the one-hot key vector and accepts each press exactly once, performing one action per accepted press. Digit keys shift into an NDIG-digit BCD entry buffer; clear, backspace and enter keys edit or commit the buffer. The live buffer drives the display; the committed value goes to downstream logic with a one-cycle strobe.

Parameters:
NDIG, 3, BCD digits in entry buffer (1..15); buffer width 4*NDIG
DEBOUNCE_CYCLES, 20, consecutive stable cycles required to accept a press or a release (>=2)
REPEAT_CYCLES, 50, auto-repeat period in cycles; used only with KEY_AUTOREPEAT_EN

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
onehot  input  16  raw keypad vector, at most one bit expected high
bcd  output  4*NDIG  live entry buffer, nibble 0 = most recently entered digit
count  output  4  digits currently in buffer, 0..NDIG
full  output  1  high when count==NDIG
value  output  4*NDIG  last committed buffer
done  output  1  one-cycle strobe when value updates
key_valid  output  1  one-cycle strobe per accepted key action
key_code  output  4  code of the last accepted key, held between strobes

Behaviour:
- Key map, exact match only: 0x0008=0, 0x0080=1, 0x0040=2, 0x0020=3, 0x0800=4, 0x0400=5, 0x0200=6, 0x8000=7, 0x4000=8, 0x2000=9, 0x0001=CLEAR (code 0xA), 0x0002=BACK (0xB), 0x0004=ENTER (0xC).
- Any other nonzero pattern (0x0010, 0x0100, 0x1000, multi-bit) is invalid and treated as no key for acceptance.
- Reset: state IDLE; bcd, count, value, key_code, internal counters = 0; done, key_valid, full = 0.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE: on a valid key, latch cand<=onehot, cnt<=0, go DEBOUNCE.
- DEBOUNCE: if onehot!=cand, go IDLE. Otherwise cnt++. At the edge where cnt==DEBOUNCE_CYCLES-1 and onehot==cand: execute the action, pulse key_valid, go HELD.
- Latency: a key first sampled at edge t has its action registered at edge t+DEBOUNCE_CYCLES.
- HELD: stay while onehot!=0. On onehot==0, cnt<=0 and go RELEASE.
- RELEASE: any nonzero onehot returns to HELD. After DEBOUNCE_CYCLES consecutive zero samples, go IDLE. A new key is accepted only after full release.
- Digit d: if count<NDIG then bcd<={bcd[4*NDIG-5:0],d} and count++. If full, the digit is dropped, but key_valid still pulses with key_code=d.
- BACK: if count>0 then bcd<=bcd>>4 and count--; otherwise no change.
- CLEAR: bcd<=0, count<=0.
- ENTER: if count>0 then value<=bcd, done=1 for one cycle, bcd<=0, count<=0. If count==0, done stays 0 and value is unchanged.
- full is registered and updates in the same cycle as count.
- Reset asserted mid-operation: everything returns to reset values immediately. A key still held after rst_n deassert is debounced and accepted as a new press.

Optional Feature:
KEY_AUTOREPEAT_EN
- Defined: in HELD, a digit or BACK key held unchanged repeats its action (with key_valid) every REPEAT_CYCLES cycles after acceptance. CLEAR and ENTER never repeat. A change of onehot restarts HELD/RELEASE handling as normal.
- Undefined: exactly one action per press, and REPEAT_CYCLES is unused.

Test Plan:
Bench settings: DEBOUNCE_CYCLES=4, NDIG=3.
- Reset: hold rst_n=0 with onehot=0x0080 -> all outputs 0; after release, key 1 accepted 4 cycles later, bcd=0x001, count=1.
- Bounce: apply 0x0040 for 3 cycles, 0 for 1 cycle, then 0x0040 for 4 cycles -> exactly one key_valid, bcd=0x002.
- Entry and commit: press 1,2,3 with full releases, then 4 -> bcd=0x123, full=1, key_valid on all 4 presses. ENTER -> value=0x123, done pulses 1 cycle, bcd=0, count=0.
- Editing: enter 5,6, then BACK -> bcd=0x005, count=1. CLEAR -> bcd=0. ENTER with count=0 -> no done pulse, value unchanged.
- Invalid keys: 0x0010 and 0x0003 held for 20 cycles -> no key_valid, state stays IDLE.
- Held key: hold 0x2000 for 100 cycles -> without macro one digit 9 is entered; with KEY_AUTOREPEAT_EN and REPEAT_CYCLES=10, three 9s are entered, then dropped once full.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Debounced 4x4 keypad sequencer feeding an NDIG-digit BCD entry buffer.
// Each accepted press performs one action: a digit shifts into the buffer,
// BACK drops the newest digit, CLEAR empties the buffer and ENTER commits it.
// The live buffer drives the display; the committed value is strobed by done.
//
// Build option: define KEY_AUTOREPEAT_EN to let a held digit or BACK key
// repeat its action every REPEAT_CYCLES cycles. Without the macro every
// press performs exactly one action and REPEAT_CYCLES is unused.

module keypad_entry_ctrl #(
    parameter int NDIG            = 3,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_CYCLES   = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         onehot,
    output logic [4*NDIG-1:0]   bcd,
    output logic [3:0]          count,
    output logic                full,
    output logic [4*NDIG-1:0]   value,
    output logic                done,
    output logic                key_valid,
    output logic [3:0]          key_code
);

    localparam int BW = 4 * NDIG;
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    NDIG_L   = 4'(NDIG);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [3:0] CODE_CLEAR = 4'hA;
    localparam logic [3:0] CODE_BACK  = 4'hB;
    localparam logic [3:0] CODE_ENTER = 4'hC;

    // Reject out-of-range parameters at elaboration.
    if (NDIG < 1 || NDIG > 15 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("keypad_entry_ctrl: parameter out of range");
    end

    // True only for one of the thirteen mapped single-bit patterns.
    function automatic logic key_is_valid(input logic [15:0] k);
        logic v;
        case (k)
            16'h0008, 16'h0080, 16'h0040, 16'h0020,
            16'h0800, 16'h0400, 16'h0200, 16'h8000,
            16'h4000, 16'h2000, 16'h0001, 16'h0002,
            16'h0004: v = 1'b1;
            default:  v = 1'b0;
        endcase
        return v;
    endfunction

    // Key code for a mapped pattern; unmapped patterns give 0 but are never
    // used because they are rejected by key_is_valid first.
    function automatic logic [3:0] key_to_code(input logic [15:0] k);
        logic [3:0] c;
        case (k)
            16'h0008: c = 4'd0;
            16'h0080: c = 4'd1;
            16'h0040: c = 4'd2;
            16'h0020: c = 4'd3;
            16'h0800: c = 4'd4;
            16'h0400: c = 4'd5;
            16'h0200: c = 4'd6;
            16'h8000: c = 4'd7;
            16'h4000: c = 4'd8;
            16'h2000: c = 4'd9;
            16'h0001: c = CODE_CLEAR;
            16'h0002: c = CODE_BACK;
            16'h0004: c = CODE_ENTER;
            default:  c = 4'd0;
        endcase
        return c;
    endfunction

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_cand;
    logic [BW-1:0] r_bcd;
    logic [3:0]    r_count;
    logic          r_full;
    logic [BW-1:0] r_value;
    logic          r_done;
    logic          r_key_valid;
    logic [3:0]    r_key_code;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [15:0]   w_cand_nxt;
    logic          w_fire;
    logic          w_in_valid;
    logic          w_in_zero;
    logic          w_in_match;
    logic          w_cnt_last;
    logic [3:0]    w_cand_code;

    assign w_in_valid  = key_is_valid(onehot);
    assign w_in_zero   = (onehot == 16'h0000);
    assign w_in_match  = (onehot == r_cand);
    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_cand_code = key_to_code(r_cand);

`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_rep_nxt;
    logic          w_repeatable;

    // Only digits and BACK auto-repeat; CLEAR and ENTER act once per press.
    assign w_repeatable = (w_cand_code <= 4'd9) || (w_cand_code == CODE_BACK);
`endif

    // Next-state, debounce counter and action-fire decode for the key FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_fire      = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        w_rep_nxt   = r_rep;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_in_valid) begin
                    w_cand_nxt  = onehot;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DEBOUNCE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_in_match) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_last) begin
                    w_fire      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HELD;
`ifdef KEY_AUTOREPEAT_EN
                    w_rep_nxt   = '0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (w_in_zero) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_HELD;
`ifdef KEY_AUTOREPEAT_EN
                    // The repeat timer only runs while the accepted key is
                    // held unchanged; any other pattern restarts it.
                    if (!w_in_match || !w_repeatable) begin
                        w_rep_nxt = '0;
                    end else if (r_rep == REP_LAST) begin
                        w_fire    = 1'b1;
                        w_rep_nxt = '0;
                    end else begin
                        w_rep_nxt = r_rep + 1'b1;
                    end
`endif
                end
            end
            ST_RELEASE: begin
                if (!w_in_zero) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HELD;
`ifdef KEY_AUTOREPEAT_EN
                    w_rep_nxt   = '0;
`endif
                end else if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Key FSM state, debounce counter and candidate key registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    // Auto-repeat timer measured from acceptance or the previous repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep <= '0;
        end else begin
            r_rep <= w_rep_nxt;
        end
    end
`endif

    // Entry buffer, commit register and strobes driven by accepted actions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd       <= '0;
            r_count     <= 4'd0;
            r_full      <= 1'b0;
            r_value     <= '0;
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
        end else begin
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
            if (w_fire) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_cand_code;
                case (w_cand_code)
                    CODE_CLEAR: begin
                        r_bcd   <= '0;
                        r_count <= 4'd0;
                        r_full  <= 1'b0;
                    end
                    CODE_BACK: begin
                        if (r_count != 4'd0) begin
                            r_bcd   <= r_bcd >> 4;
                            r_count <= r_count - 4'd1;
                            r_full  <= 1'b0;
                        end else begin
                            r_bcd   <= r_bcd;
                        end
                    end
                    CODE_ENTER: begin
                        // An empty buffer commits nothing and raises no strobe.
                        if (r_count != 4'd0) begin
                            r_value <= r_bcd;
                            r_done  <= 1'b1;
                            r_bcd   <= '0;
                            r_count <= 4'd0;
                            r_full  <= 1'b0;
                        end else begin
                            r_value <= r_value;
                        end
                    end
                    default: begin
                        // Digits 0..9: shift in unless full, in which case the
                        // digit is dropped but still reported via key_code.
                        if (r_count < NDIG_L) begin
                            r_bcd   <= (r_bcd << 4) | BW'(w_cand_code);
                            r_count <= r_count + 4'd1;
                            r_full  <= ((r_count + 4'd1) == NDIG_L);
                        end else begin
                            r_bcd   <= r_bcd;
                        end
                    end
                endcase
            end else begin
                r_bcd <= r_bcd;
            end
        end
    end

    assign bcd       = r_bcd;
    assign count     = r_count;
    assign full      = r_full;
    assign value     = r_value;
    assign done      = r_done;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed self-checking bench for keypad_entry_ctrl (NDIG=3, DEBOUNCE_CYCLES=4).
module tb_keypad_entry_ctrl;

    localparam int NDIG = 3;
    localparam int DC   = 4;
    localparam int RC   = 10;

    localparam logic [15:0] K0 = 16'h0008, K1 = 16'h0080, K2 = 16'h0040, K3 = 16'h0020;
    localparam logic [15:0] K4 = 16'h0800, K5 = 16'h0400, K6 = 16'h0200, K9 = 16'h2000;
    localparam logic [15:0] K7 = 16'h8000;
    localparam logic [15:0] KCLR = 16'h0001, KBACK = 16'h0002, KENT = 16'h0004;

    logic              clk;
    logic              rst_n;
    logic [15:0]       onehot;
    logic [4*NDIG-1:0] bcd;
    logic [3:0]        count;
    logic              full;
    logic [4*NDIG-1:0] value;
    logic              done;
    logic              key_valid;
    logic [3:0]        key_code;

    int n_checks;
    int n_errors;
    int kv_cnt;
    int done_cnt;
    int kv_base;
    int done_base;

    keypad_entry_ctrl #(
        .NDIG           (NDIG),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_CYCLES  (RC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .onehot   (onehot),
        .bcd      (bcd),
        .count    (count),
        .full     (full),
        .value    (value),
        .done     (done),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_cnt = kv_cnt + 1;
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold a key for the given number of cycles, then fully release it.
    task automatic press(input logic [15:0] k, input int hold);
        onehot = k;
        cycles(hold);
        onehot = 16'h0000;
        cycles(12);
    endtask

    task automatic mark;
        kv_base   = kv_cnt;
        done_base = done_cnt;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        kv_cnt   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        onehot   = K1;

        // Reset held with a key pressed: everything stays at zero.
        cycles(3);
        check_eq("rst_bcd",   32'(bcd),       32'h0);
        check_eq("rst_count", 32'(count),     32'h0);
        check_eq("rst_full",  32'(full),      32'h0);
        check_eq("rst_value", 32'(value),     32'h0);
        check_eq("rst_done",  32'(done),      32'h0);
        check_eq("rst_kv",    32'(key_valid), 32'h0);
        check_eq("rst_code",  32'(key_code),  32'h0);

        // Still-held key accepted exactly DC edges after the first sample.
        rst_n = 1'b1;
        cycles(DC);
        check_eq("lat_kv_early", 32'(key_valid), 32'h0);
        cycles(1);
        check_eq("lat_kv",    32'(key_valid), 32'h1);
        check_eq("lat_code",  32'(key_code),  32'h1);
        check_eq("lat_bcd",   32'(bcd),       32'h001);
        check_eq("lat_count", 32'(count),     32'h1);
        cycles(1);
        check_eq("lat_kv_1cyc", 32'(key_valid), 32'h0);
        onehot = 16'h0000;
        cycles(12);

        // Bounce: a 3-cycle burst is rejected, the steady press accepted once.
        press(KCLR, 8);
        mark();
        onehot = K2;
        cycles(3);
        onehot = 16'h0000;
        cycles(1);
        press(K2, 8);
        check_eq("bounce_kv",  32'(kv_cnt - kv_base), 32'd1);
        check_eq("bounce_bcd", 32'(bcd),              32'h002);

        // Entry to full, a dropped fourth digit, then commit.
        press(KCLR, 8);
        mark();
        press(K1, 8);
        press(K2, 8);
        press(K3, 8);
        check_eq("entry_bcd",   32'(bcd),   32'h123);
        check_eq("entry_count", 32'(count), 32'h3);
        check_eq("entry_full",  32'(full),  32'h1);
        press(K4, 8);
        check_eq("drop_bcd",  32'(bcd),              32'h123);
        check_eq("drop_code", 32'(key_code),         32'h4);
        check_eq("drop_kv",   32'(kv_cnt - kv_base), 32'd4);
        mark();
        press(KENT, 8);
        check_eq("enter_value", 32'(value),                  32'h123);
        check_eq("enter_done",  32'(done_cnt - done_base),   32'd1);
        check_eq("enter_bcd",   32'(bcd),                    32'h0);
        check_eq("enter_count", 32'(count),                  32'h0);
        check_eq("enter_full",  32'(full),                   32'h0);

        // Editing: backspace, clear, empty enter, backspace on empty.
        press(K5, 8);
        press(K6, 8);
        check_eq("edit_bcd56", 32'(bcd), 32'h056);
        press(KBACK, 8);
        check_eq("back_bcd",   32'(bcd),      32'h005);
        check_eq("back_count", 32'(count),    32'h1);
        check_eq("back_code",  32'(key_code), 32'hB);
        press(KCLR, 8);
        check_eq("clr_bcd",   32'(bcd),   32'h0);
        check_eq("clr_count", 32'(count), 32'h0);
        mark();
        press(KENT, 8);
        check_eq("empty_done",  32'(done_cnt - done_base), 32'd0);
        check_eq("empty_value", 32'(value),                32'h123);
        check_eq("empty_code",  32'(key_code),             32'hC);
        press(KBACK, 8);
        check_eq("back0_count", 32'(count), 32'h0);
        check_eq("back0_bcd",   32'(bcd),   32'h0);

        // Invalid patterns never produce an action; a later key still works.
        mark();
        onehot = 16'h0010;
        cycles(20);
        onehot = 16'h0003;
        cycles(20);
        onehot = 16'h0000;
        cycles(2);
        check_eq("inv_kv", 32'(kv_cnt - kv_base), 32'd0);
        press(K7, 8);
        check_eq("inv_then_bcd", 32'(bcd), 32'h007);
        press(K0, 8);
        check_eq("digit0_bcd", 32'(bcd), 32'h070);

        // Long hold of digit 9.
        press(KCLR, 8);
        mark();
        press(K9, 100);
`ifdef KEY_AUTOREPEAT_EN
        check_eq("hold_kv",    32'(kv_cnt - kv_base), 32'd10);
        check_eq("hold_bcd",   32'(bcd),              32'h999);
        check_eq("hold_count", 32'(count),            32'h3);
`else
        check_eq("hold_kv",    32'(kv_cnt - kv_base), 32'd1);
        check_eq("hold_bcd",   32'(bcd),              32'h009);
        check_eq("hold_count", 32'(count),            32'h1);
`endif

        // Reset mid-press clears everything at once.
        onehot = K3;
        cycles(2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_bcd",   32'(bcd),   32'h0);
        check_eq("midrst_value", 32'(value), 32'h0);
        check_eq("midrst_code",  32'(key_code), 32'h0);
        onehot = 16'h0000;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
